// File: rtl/decode_stage.sv
// decode_stage: two-lane instruction decode register stage.
// Accepts up to two instructions per cycle from the instruction buffer and
// presents them to rename one cycle later. A lone lane-1 instruction is
// moved down to output lane 0. Each lane gets an opclass, its source and
// destination registers, an immediate and an exception flag.
// Handshake: a transfer happens on a rising edge where ib_ready && |ib_valid
// (input side) or |dec_valid && dec_ready (output side). While the outputs
// are valid and not accepted, they are held stable and ib_ready is low.
// Optional build macro DECODE_PERF_CNT_EN adds the perf_dec_cnt and
// perf_stall_cnt counter outputs.
module decode_stage #(
    parameter int INVALID_TRAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  ib_valid,
    output logic        ib_ready,
    input  logic [31:0] ib_pc0,
    input  logic [31:0] ib_pc1,
    input  logic [31:0] ib_inst0,
    input  logic [31:0] ib_inst1,
    output logic [1:0]  dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc0,
    output logic [2:0]  dec_opclass0,
    output logic [4:0]  dec_rs0,
    output logic [4:0]  dec_rt0,
    output logic [4:0]  dec_dst0,
    output logic [31:0] dec_imm0,
    output logic        dec_exc0,
    output logic [31:0] dec_pc1,
    output logic [2:0]  dec_opclass1,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rt1,
    output logic [4:0]  dec_dst1,
    output logic [31:0] dec_imm1,
    output logic        dec_exc1
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0] perf_dec_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [2:0] OC_ALU     = 3'd0;
    localparam logic [2:0] OC_BRANCH  = 3'd1;
    localparam logic [2:0] OC_JUMP    = 3'd2;
    localparam logic [2:0] OC_LOAD    = 3'd3;
    localparam logic [2:0] OC_STORE   = 3'd4;
    localparam logic [2:0] OC_MULDIV  = 3'd5;
    localparam logic [2:0] OC_PRIV    = 3'd6;
    localparam logic [2:0] OC_INVALID = 3'd7;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  opclass;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic        exc;
    } lane_t;

    // Pure combinational decode of one instruction word.
    function automatic lane_t decode_lane(input logic [31:0] pc, input logic [31:0] inst);
        lane_t      d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rd;
        logic       known;
        op      = inst[31:26];
        fn      = inst[5:0];
        rd      = inst[15:11];
        known   = 1'b1;
        d       = '0;
        d.pc    = pc;
        d.rs    = inst[25:21];
        d.rt    = inst[20:16];
        d.opclass = OC_ALU;
        d.dst   = 5'd0;
        d.exc   = 1'b0;

        case (op)
            6'h0C, 6'h0D, 6'h0E: d.imm = {16'h0000, inst[15:0]};
            6'h0F:               d.imm = {inst[15:0], 16'h0000};
            6'h02, 6'h03:        d.imm = {6'b0, inst[25:0]};
            default:             d.imm = {{16{inst[15]}}, inst[15:0]};
        endcase

        case (op)
            6'h00: begin
                case (fn)
                    6'h08: d.opclass = OC_JUMP;
                    6'h09: begin d.opclass = OC_JUMP; d.dst = rd; end
                    6'h0C, 6'h0D: d.opclass = OC_PRIV;
                    // mfhi/mflo write a GPR; mthi/mtlo/mult/div only touch hi/lo.
                    6'h10, 6'h12: begin d.opclass = OC_MULDIV; d.dst = rd; end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: d.opclass = OC_MULDIV;
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin d.opclass = OC_ALU; d.dst = rd; end
                    default: known = 1'b0;
                endcase
            end
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: d.opclass = OC_BRANCH;
            6'h02: d.opclass = OC_JUMP;
            6'h03: begin d.opclass = OC_JUMP; d.dst = 5'd31; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                d.opclass = OC_ALU;
                d.dst     = inst[20:16];
            end
            6'h10: d.opclass = OC_PRIV;
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: begin
                d.opclass = OC_LOAD;
                d.dst     = inst[20:16];
            end
            6'h28, 6'h29, 6'h2B: d.opclass = OC_STORE;
            default: known = 1'b0;
        endcase

        // Undefined encodings either trap or degrade to a harmless ALU no-op.
        if (!known) begin
            d.dst = 5'd0;
            if (INVALID_TRAP != 0) begin
                d.opclass = OC_INVALID;
                d.exc     = 1'b1;
            end else begin
                d.opclass = OC_ALU;
                d.exc     = 1'b0;
            end
        end
        return d;
    endfunction

    lane_t      lane0_q;
    lane_t      lane1_q;
    logic [1:0] valid_q;
    lane_t      in0;
    lane_t      in1;
    logic       accept;

    // Ready when the output slot is empty or being drained; never during flush.
    always_comb begin
        ib_ready = !flush && (!(|valid_q) || dec_ready);
        accept   = ib_ready && (|ib_valid);
    end

    // Decode both incoming lanes; a lone lane-1 instruction moves to lane 0.
    always_comb begin
        in0 = ib_valid[0] ? decode_lane(ib_pc0, ib_inst0) : decode_lane(ib_pc1, ib_inst1);
        in1 = decode_lane(ib_pc1, ib_inst1);
    end

    // Pipeline register: reset beats flush, flush beats accept, accept beats drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 2'b00;
            lane0_q <= '0;
            lane1_q <= '0;
        end else if (flush) begin
            valid_q <= 2'b00;
        end else if (accept) begin
            valid_q <= (ib_valid == 2'b11) ? 2'b11 : 2'b01;
            lane0_q <= in0;
            lane1_q <= (ib_valid == 2'b11) ? in1 : '0;
        end else if (dec_ready) begin
            valid_q <= 2'b00;
        end
    end

    // Flatten the lane registers onto the output ports.
    always_comb begin
        dec_valid    = valid_q;
        dec_pc0      = lane0_q.pc;
        dec_opclass0 = lane0_q.opclass;
        dec_rs0      = lane0_q.rs;
        dec_rt0      = lane0_q.rt;
        dec_dst0     = lane0_q.dst;
        dec_imm0     = lane0_q.imm;
        dec_exc0     = lane0_q.exc;
        dec_pc1      = lane1_q.pc;
        dec_opclass1 = lane1_q.opclass;
        dec_rs1      = lane1_q.rs;
        dec_rt1      = lane1_q.rt;
        dec_dst1     = lane1_q.dst;
        dec_imm1     = lane1_q.imm;
        dec_exc1     = lane1_q.exc;
    end

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] out_count;

    // Number of instructions leaving on this cycle's downstream handshake.
    always_comb begin
        out_count = 32'd0;
        if (dec_ready) begin
            out_count = {31'd0, valid_q[0]} + {31'd0, valid_q[1]};
        end
    end

    // Free-running counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dec_cnt   <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            perf_dec_cnt <= perf_dec_cnt + out_count;
            if ((|valid_q) && !dec_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage with two instances,
// one trapping undefined opcodes and one decoding them as ALU no-ops.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  ib_valid;
    logic [31:0] ib_pc0, ib_pc1, ib_inst0, ib_inst1;
    logic        dec_ready;

    logic        t_ib_ready, n_ib_ready;
    logic [1:0]  t_valid, n_valid;
    logic [31:0] t_pc0, t_pc1, n_pc0, n_pc1;
    logic [2:0]  t_oc0, t_oc1, n_oc0, n_oc1;
    logic [4:0]  t_rs0, t_rt0, t_dst0, t_rs1, t_rt1, t_dst1;
    logic [4:0]  n_rs0, n_rt0, n_dst0, n_rs1, n_rt1, n_dst1;
    logic [31:0] t_imm0, t_imm1, n_imm0, n_imm1;
    logic        t_exc0, t_exc1, n_exc0, n_exc1;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] t_perf_dec, t_perf_stall, n_perf_dec, n_perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    decode_stage #(.INVALID_TRAP(1)) u_trap (
        .clk(clk), .rst(rst), .flush(flush),
        .ib_valid(ib_valid), .ib_ready(t_ib_ready),
        .ib_pc0(ib_pc0), .ib_pc1(ib_pc1), .ib_inst0(ib_inst0), .ib_inst1(ib_inst1),
        .dec_valid(t_valid), .dec_ready(dec_ready),
        .dec_pc0(t_pc0), .dec_opclass0(t_oc0), .dec_rs0(t_rs0), .dec_rt0(t_rt0),
        .dec_dst0(t_dst0), .dec_imm0(t_imm0), .dec_exc0(t_exc0),
        .dec_pc1(t_pc1), .dec_opclass1(t_oc1), .dec_rs1(t_rs1), .dec_rt1(t_rt1),
        .dec_dst1(t_dst1), .dec_imm1(t_imm1), .dec_exc1(t_exc1)
`ifdef DECODE_PERF_CNT_EN
        , .perf_dec_cnt(t_perf_dec), .perf_stall_cnt(t_perf_stall)
`endif
    );

    decode_stage #(.INVALID_TRAP(0)) u_notrap (
        .clk(clk), .rst(rst), .flush(flush),
        .ib_valid(ib_valid), .ib_ready(n_ib_ready),
        .ib_pc0(ib_pc0), .ib_pc1(ib_pc1), .ib_inst0(ib_inst0), .ib_inst1(ib_inst1),
        .dec_valid(n_valid), .dec_ready(dec_ready),
        .dec_pc0(n_pc0), .dec_opclass0(n_oc0), .dec_rs0(n_rs0), .dec_rt0(n_rt0),
        .dec_dst0(n_dst0), .dec_imm0(n_imm0), .dec_exc0(n_exc0),
        .dec_pc1(n_pc1), .dec_opclass1(n_oc1), .dec_rs1(n_rs1), .dec_rt1(n_rt1),
        .dec_dst1(n_dst1), .dec_imm1(n_imm1), .dec_exc1(n_exc1)
`ifdef DECODE_PERF_CNT_EN
        , .perf_dec_cnt(n_perf_dec), .perf_stall_cnt(n_perf_stall)
`endif
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] i0,
                         input logic [31:0] pc1, input logic [31:0] i1);
        ib_valid = v;
        ib_pc0   = pc0;
        ib_inst0 = i0;
        ib_pc1   = pc1;
        ib_inst1 = i1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dec_ready = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_valid", {30'd0, t_valid}, 32'd0);
        check("reset_pc0", t_pc0, 32'd0);
        check("reset_imm0", t_imm0, 32'd0);
        check("reset_oc1", {29'd0, t_oc1}, 32'd0);
        check("reset_ib_ready", {31'd0, t_ib_ready}, 32'd1);
`ifdef DECODE_PERF_CNT_EN
        check("reset_perf_dec", t_perf_dec, 32'd0);
        check("reset_perf_stall", t_perf_stall, 32'd0);
`endif

        // Dual accept: addiu $2,$0,5 and lw $3,4($2).
        drive(2'b11, 32'h100, 32'h24020005, 32'h104, 32'h8C430004);
        #1;
        check("dual_ib_ready", {31'd0, t_ib_ready}, 32'd1);
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        check("dual_valid", {30'd0, t_valid}, 32'd3);
        check("dual_oc0", {29'd0, t_oc0}, 32'd0);
        check("dual_dst0", {27'd0, t_dst0}, 32'd2);
        check("dual_imm0", t_imm0, 32'd5);
        check("dual_rt0", {27'd0, t_rt0}, 32'd2);
        check("dual_oc1", {29'd0, t_oc1}, 32'd3);
        check("dual_dst1", {27'd0, t_dst1}, 32'd3);
        check("dual_imm1", t_imm1, 32'd4);
        check("dual_rs1", {27'd0, t_rs1}, 32'd2);
        check("dual_pc1", t_pc1, 32'h104);
        check("dual_exc0", {31'd0, t_exc0}, 32'd0);

        // Bubble: consumed with nothing new.
        tick();
        check("bubble_valid", {30'd0, t_valid}, 32'd0);
`ifdef DECODE_PERF_CNT_EN
        check("bubble_perf_dec", t_perf_dec, 32'd2);
`endif

        // Load jal 0x40 and sw $31,8($29), then stall three cycles.
        drive(2'b11, 32'h200, 32'h0C000010, 32'h204, 32'hAFBF0008);
        tick();
        dec_ready = 1'b0;
        drive(2'b11, 32'h300, 32'h00851020, 32'h304, 32'h00850018);
        #1;
        check("stall_ib_ready", {31'd0, t_ib_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {30'd0, t_valid}, 32'd3);
            check("stall_pc0", t_pc0, 32'h200);
            check("stall_oc0", {29'd0, t_oc0}, 32'd2);
            check("stall_dst0", {27'd0, t_dst0}, 32'd31);
            check("stall_imm0", t_imm0, 32'h10);
            check("stall_oc1", {29'd0, t_oc1}, 32'd4);
            check("stall_dst1", {27'd0, t_dst1}, 32'd0);
            check("stall_rs1", {27'd0, t_rs1}, 32'd29);
            check("stall_imm1", t_imm1, 32'd8);
            check("stall_ib_ready_held", {31'd0, t_ib_ready}, 32'd0);
        end
`ifdef DECODE_PERF_CNT_EN
        check("stall_perf_stall", t_perf_stall, 32'd3);
`endif

        // Release: add $2,$4,$5 and mult $4,$5 transfer in.
        dec_ready = 1'b1;
        #1;
        check("release_ib_ready", {31'd0, t_ib_ready}, 32'd1);
        tick();
        check("release_valid", {30'd0, t_valid}, 32'd3);
        check("release_pc0", t_pc0, 32'h300);
        check("release_oc0", {29'd0, t_oc0}, 32'd0);
        check("release_dst0", {27'd0, t_dst0}, 32'd2);
        check("release_oc1", {29'd0, t_oc1}, 32'd5);
        check("release_dst1", {27'd0, t_dst1}, 32'd0);
`ifdef DECODE_PERF_CNT_EN
        check("release_perf_dec", t_perf_dec, 32'd4);
        check("release_perf_stall", t_perf_stall, 32'd3);
`endif

        // Flush during stall with new instructions offered.
        dec_ready = 1'b0;
        flush = 1'b1;
        drive(2'b11, 32'h400, 32'h24020005, 32'h404, 32'h24030006);
        #1;
        check("flush_ib_ready_low", {31'd0, t_ib_ready}, 32'd0);
        tick();
        flush = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("flush_valid", {30'd0, t_valid}, 32'd0);
        check("flush_ib_ready", {31'd0, t_ib_ready}, 32'd1);
`ifdef DECODE_PERF_CNT_EN
        check("flush_perf_stall", t_perf_stall, 32'd4);
`endif

        // Compaction: lone lane-1 lui $1,0xABCD.
        dec_ready = 1'b1;
        drive(2'b10, 32'h500, 32'hFFFFFFFF, 32'hBFC00004, 32'h3C01ABCD);
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        check("compact_valid", {30'd0, t_valid}, 32'd1);
        check("compact_pc0", t_pc0, 32'hBFC00004);
        check("compact_imm0", t_imm0, 32'hABCD0000);
        check("compact_dst0", {27'd0, t_dst0}, 32'd1);
        check("compact_oc0", {29'd0, t_oc0}, 32'd0);

        // Undefined opcode 0x3F in both configurations.
        drive(2'b01, 32'h600, 32'hFC000000, 32'h604, 32'h0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        check("inv_trap_valid", {30'd0, t_valid}, 32'd1);
        check("inv_trap_oc0", {29'd0, t_oc0}, 32'd7);
        check("inv_trap_exc0", {31'd0, t_exc0}, 32'd1);
        check("inv_trap_dst0", {27'd0, t_dst0}, 32'd0);
        check("inv_notrap_valid", {30'd0, n_valid}, 32'd1);
        check("inv_notrap_oc0", {29'd0, n_oc0}, 32'd0);
        check("inv_notrap_exc0", {31'd0, n_exc0}, 32'd0);
        check("inv_notrap_dst0", {27'd0, n_dst0}, 32'd0);

        // beq $2,$3,-2 and ori $2,$2,0x8001: sign vs zero extension.
        drive(2'b11, 32'h700, 32'h1043FFFE, 32'h704, 32'h34428001);
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        check("beq_oc0", {29'd0, t_oc0}, 32'd1);
        check("beq_imm0", t_imm0, 32'hFFFFFFFE);
        check("beq_dst0", {27'd0, t_dst0}, 32'd0);
        check("beq_rs0", {27'd0, t_rs0}, 32'd2);
        check("beq_rt0", {27'd0, t_rt0}, 32'd3);
        check("ori_imm1", t_imm1, 32'h00008001);
        check("ori_dst1", {27'd0, t_dst1}, 32'd2);
        check("notrap_ori_imm1", n_imm1, 32'h00008001);

        // Reset while stalled with a full register.
        drive(2'b11, 32'h800, 32'h24020005, 32'h804, 32'h8C430004);
        tick();
        dec_ready = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("pre_reset_valid", {30'd0, t_valid}, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_valid", {30'd0, t_valid}, 32'd0);
        check("midrst_pc0", t_pc0, 32'd0);
        check("midrst_imm1", t_imm1, 32'd0);
        check("midrst_dst1", {27'd0, t_dst1}, 32'd0);
        check("midrst_oc1", {29'd0, t_oc1}, 32'd0);
        check("midrst_ib_ready", {31'd0, t_ib_ready}, 32'd1);
        check("midrst_notrap_valid", {30'd0, n_valid}, 32'd0);
`ifdef DECODE_PERF_CNT_EN
        check("midrst_perf_dec", t_perf_dec, 32'd0);
        check("midrst_perf_stall", t_perf_stall, 32'd0);
`endif
        tick();
        check("midrst_no_output", {30'd0, t_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter INVALID_TRAP, default 1, meaning: 1 = undefined opcodes flagged as exception, 0 = decoded as NOP-class ALU.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: flush  in  1  backend redirect, kills all held and incoming instructions.
REQ-004 SHALL have ports: ib_valid  in  2  per-lane valid from instruction buffer; ib_ready  out  1  stage accepts this cycle.
REQ-005 SHALL have ports: ib_pc0/ib_pc1  in  32  lane PCs; ib_inst0/ib_inst1  in  32  lane instruction words.
REQ-006 SHALL have ports: dec_valid  out  2  per-lane decoded valid; dec_ready  in  1  downstream (rename) accepts.
REQ-007 SHALL have per-lane outputs (x=0,1): dec_pcx  out  32; dec_opclassx  out  3; dec_rsx, dec_rtx, dec_dstx  out  5 each; dec_immx  out  32; dec_excx  out  1.

Function
REQ-008 SHALL be one register stage: lanes accepted at cycle N appear on dec_* at N+1.
REQ-009 SHALL drive ib_ready = !(|dec_valid) || dec_ready, combinationally, forced 0 while flush=1.
REQ-010 SHALL transfer input when ib_ready && |ib_valid; SHALL hold outputs stable while |dec_valid && !dec_ready.
REQ-011 SHALL clear dec_valid when outputs are consumed and no new input arrives (bubble).
REQ-012 SHALL compact lanes: ib_valid=2'b10 places lane-1 instruction (pc, inst) on output lane 0, dec_valid=2'b01.
REQ-013 SHALL set dec_valid=0 on the cycle after flush=1, regardless of dec_ready or ib_valid; flush wins over simultaneous accept.
REQ-014 SHALL encode opclass: 0 ALU, 1 BRANCH (op 0x01/0x04-0x07), 2 JUMP (op 0x02/0x03, funct 0x08/0x09), 3 LOAD (op 0x20-0x25), 4 STORE (op 0x28/0x29/0x2B), 5 MULDIV (funct 0x10-0x13, 0x18-0x1B), 6 PRIV (op 0x10, funct 0x0C/0x0D), 7 INVALID.
REQ-015 SHALL set dst: rd for SPECIAL R-type, rt for I-type ALU and loads, 31 for op 0x03, 0 for branch/store/j/muldiv-without-GPR-write/priv.
REQ-016 SHALL form imm: zero-extended for op 0x0C-0x0E, {inst[15:0],16'h0} for op 0x0F, {6'b0,inst[25:0]} for op 0x02/0x03, else sign-extended inst[15:0].
REQ-017 SHALL set dec_excx=1 and opclass 7 for undefined encodings when INVALID_TRAP=1; with INVALID_TRAP=0 SHALL output opclass 0, dst 0, exc 0.
REQ-018 SHALL pass rs=inst[25:21], rt=inst[20:16] unmodified for all classes.

Reset
REQ-019 SHALL, on rst=1 at a clock edge, set dec_valid=0 and all dec_* data outputs to 0; ib_ready=1 on the following cycle.
REQ-020 SHALL treat rst mid-stall identically: held instructions discarded, no output until new transfer.
REQ-021 SHALL give rst priority over flush and transfer.

Configuration
REQ-022 SHALL, when DECODE_PERF_CNT_EN is defined, add outputs perf_dec_cnt  out  32 (instructions transferred out, +0/+1/+2 per cycle) and perf_stall_cnt  out  32 (cycles with |dec_valid && !dec_ready), both reset to 0, wrapping modulo 2^32, not cleared by flush.
REQ-023 SHALL, when DECODE_PERF_CNT_EN is undefined, omit both ports and counters, with no change to any other behaviour.

Verification
REQ-024 Dual accept: ib_valid=2'b11, inst0=0x24020005 (addiu), inst1=0x8C430004 (lw), dec_ready=1 -> next cycle dec_valid=2'b11, opclass0=0 dst0=2 imm0=5, opclass1=3 dst1=3 imm1=4.
REQ-025 Backpressure: dec_ready=0 for 3 cycles with held valid -> ib_ready=0, dec_* stable all 3 cycles; dec_ready=1 -> transfer, perf_stall_cnt=3 if enabled.
REQ-026 Flush during stall: dec_valid=2'b11, dec_ready=0, flush=1 with ib_valid=2'b11 -> next cycle dec_valid=0, ib_ready=1.
REQ-027 Compaction/imm: ib_valid=2'b10, inst1=0x3C01ABCD (lui), pc1=0xBFC00004 -> dec_valid=2'b01, dec_pc0=0xBFC00004, dec_imm0=0xABCD0000, dst0=1.
REQ-028 Invalid opcode: inst0=0xFC000000 -> INVALID_TRAP=1: opclass0=7, exc0=1; INVALID_TRAP=0: opclass0=0, exc0=0, dst0=0.
REQ-029 Reset mid-operation: rst=1 while dec_valid=2'b11, dec_ready=0 -> next cycle dec_valid=0, all data 0, counters 0.
